// File: rtl/signed_dot_pkg.sv
// Shared encodings and default widths for the signed dot-product accumulator.
package signed_dot_pkg;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/acc_sat_adder.sv
// Combinational accumulate step: sign-extend product, add, flag overflow.
// Clamping on overflow is enabled by defining SIGNED_DOT_ACC_SAT_EN; otherwise the sum wraps.
module acc_sat_adder
  import signed_dot_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf_now
);

  logic signed [ACC_W-1:0] acc_s;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] raw;

  assign acc_s    = acc;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign raw      = acc_s + prod_ext;
  // Same-sign addends producing an opposite-sign result is the only overflow case.
  assign ovf_now  = (acc_s[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != acc_s[ACC_W-1]);

`ifdef SIGNED_DOT_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W-1:0] r,
                                                     input logic ovf, input logic neg);
    if (!ovf) return r;
    return neg ? SUM_MIN : SUM_MAX;
  endfunction

  assign sum = clamp(raw, ovf_now, acc_s[ACC_W-1]);
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/signed_dot_accumulator.sv
// Packet-wise signed accumulator for the multiplier product stream with a valid/ready result port.
// Saturating accumulation is selected with SIGNED_DOT_ACC_SAT_EN (wrap-around by default).
module signed_dot_accumulator
  import signed_dot_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic                    ovf_p0;

  logic [ACC_W-1:0] sum;
  logic             ovf_now;
  logic             accept;
  logic             release_res;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_new;

  acc_sat_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc     (acc_p0),
    .prod    (in_prod),
    .sum     (sum),
    .ovf_now (ovf_now)
  );

  assign in_ready    = (state != HOLD);
  assign out_valid   = (state == HOLD);
  assign accept      = in_valid && in_ready;
  assign release_res = (state == HOLD) && out_ready;
  assign cnt_inc     = (cnt_p0 == '1) ? cnt_p0 : cnt_p0 + 1'b1;
  assign ovf_new     = ovf_p0 | ovf_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = in_last ? HOLD : ACCUM;
      HOLD:        if (out_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
    if (acc_clr) state_nxt = IDLE;
  end

  // Stage p0: running packet sum, term count and sticky overflow; result holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0    <= '0;
      cnt_p0    <= '0;
      ovf_p0    <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (acc_clr || release_res) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
      ovf_p0 <= 1'b0;
    end else if (accept && !in_last) begin
      acc_p0 <= sum;
      cnt_p0 <= cnt_inc;
      ovf_p0 <= ovf_new;
    end else if (accept) begin
      out_acc   <= sum;
      out_count <= cnt_inc;
      out_ovf   <= ovf_new;
    end
  end

endmodule

// File: tb/tb_signed_dot_accumulator.sv
// Scoreboard bench for signed_dot_accumulator: directed packets plus randomized traffic.
module tb_signed_dot_accumulator;

  localparam longint RES_MAX = 8388607;
  localparam longint RES_MIN = -8388608;
  localparam longint RES_SPAN = 16777216;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_acc;
  logic [9:0]  out_count;
  logic        out_ovf;

  int n_pass = 0;
  int n_total = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [23:0] acc;
    logic [9:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  signed_dot_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_clr   (acc_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: a result leaves the block on every accepted output handshake.
  always @(negedge clk) begin
    if (rst_n && !acc_clr && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got acc %0h count %0d with no result expected", out_acc, out_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_acc", out_acc, e.acc);
        chk("out_count", out_count, e.cnt);
        chk("out_ovf", out_ovf, e.ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic push(input logic [23:0] a, input logic [9:0] c, input logic o);
    exp_t e;
    e.acc = a;
    e.cnt = c;
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic send(input logic [15:0] p, input logic l);
    int guard = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    while (!in_ready && guard < 300) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", guard);
    end
    tick();
    in_valid = 1'b0;
    in_prod  = 16'($urandom);
    in_last  = 1'($urandom);
    if (l) chk("latency_out_valid", out_valid, 1);
  endtask

  // Reference: plain integer sum per packet, checked against the signed result range.
  task automatic rand_packet(input int len, input bit big);
    logic [15:0] terms[$];
    longint acc = 0;
    longint s;
    bit ovf = 1'b0;
    bit neg = 1'($urandom);
    logic [15:0] p;
    for (int i = 0; i < len; i++) begin
      if (big) p = neg ? 16'(-32768 + $urandom_range(0, 60)) : 16'(32767 - $urandom_range(0, 60));
      else     p = 16'($urandom);
      terms.push_back(p);
      s = acc + longint'($signed(p));
      if (s > RES_MAX || s < RES_MIN) begin
        ovf = 1'b1;
`ifdef SIGNED_DOT_ACC_SAT_EN
        s = (s > RES_MAX) ? RES_MAX : RES_MIN;
`else
        s = (s > RES_MAX) ? s - RES_SPAN : s + RES_SPAN;
`endif
      end
      acc = s;
    end
    push(acc[23:0], (len > 1023) ? 10'd1023 : 10'(len), ovf);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      send(terms[i], i == len - 1);
    end
  endtask

  initial begin
    int guard;
    // Reset state
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    push(24'd77, 10'd3, 1'b0);
    send(16'd12, 0);
    send(-16'sd35, 0);
    send(16'd100, 1);
    tick();

    push(-24'sd16256, 10'd1, 1'b0);
    send(-16'sd16256, 1);
    tick();

`ifdef SIGNED_DOT_ACC_SAT_EN
    push(24'h7FFFFF, 10'd512, 1'b1);
`else
    push(24'h800000, 10'd512, 1'b1);
`endif
    for (int i = 0; i < 512; i++) send(16'd16384, i == 511);
    tick();

    push(24'd1030, 10'd1023, 1'b0);
    for (int i = 0; i < 1030; i++) send(16'd1, i == 1029);
    tick();

    // Result held while the consumer stalls and new input is offered
    out_ready = 1'b0;
    push(24'd7, 10'd1, 1'b0);
    send(16'd7, 1);
    in_valid = 1'b1;
    in_prod  = 16'd999;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_acc", out_acc, 24'd7);
      chk("hold_out_count", out_count, 10'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    push(24'd7, 10'd2, 1'b0);
    send(16'd3, 0);
    send(16'd4, 1);
    tick();

    // Abort with a simultaneous last term
    send(16'd10, 0);
    send(16'd20, 0);
    in_valid = 1'b1;
    in_prod  = 16'd30;
    in_last  = 1'b1;
    acc_clr  = 1'b1;
    tick();
    acc_clr  = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    tick();
    tick();
    chk("clr_no_result", out_valid, 0);
    push(24'd9, 10'd1, 1'b0);
    send(16'd9, 1);
    tick();

    // Asynchronous reset in the middle of a packet
    send(16'd1, 0);
    send(16'd2, 0);
    send(16'd3, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_acc", out_acc, 0);
    chk("arst_out_count", out_count, 0);
    chk("arst_out_ovf", out_ovf, 0);
    chk("arst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    push(24'd5, 10'd1, 1'b0);
    send(16'd5, 1);
    tick();

    // Randomized traffic with a stalling consumer
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) rand_packet($urandom_range(256, 320), 1'b1);
      else                           rand_packet($urandom_range(1, 20), 1'b0);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
